// File: rtl/adder_seq_ctrl_if.sv
// Request/result bundle for the limb-serial add/subtract sequencer.
// The slave side is the sequencer; the master side is the requester and consumer.
interface adder_seq_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 8 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract built around a single shared 8-bit ripple adder.
// Limbs are processed LSB first, one per cycle, with the carry held between limbs.
module adder_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_seq_ctrl_if.slave     bus,
  output logic [1:0]          o_dbg_state
);
  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held by its source until then, and payload is stable.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sub;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [IDX_W+2:0] w_base;
  logic [7:0]       w_a_l;
  logic [7:0]       w_b_l;
  logic [7:0]       w_low;
  logic [1:0]       w_top;
  logic [7:0]       w_limb_sum;
  logic             w_c7;
  logic             w_c8;

  // Split at bit 7 so the carry into the sign bit is visible for overflow.
  assign w_base     = {r_idx, 3'b000};
  assign w_a_l      = r_a[w_base +: 8];
  assign w_b_l      = r_b[w_base +: 8] ^ {8{r_sub}};
  assign w_low      = {1'b0, w_a_l[6:0]} + {1'b0, w_b_l[6:0]} + {7'd0, r_carry};
  assign w_c7       = w_low[7];
  assign w_top      = {1'b0, w_a_l[7]} + {1'b0, w_b_l[7]} + {1'b0, w_c7};
  assign w_c8       = w_top[1];
  assign w_limb_sum = {w_top[0], w_low[6:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.op_a;
            r_b        <= bus.op_b;
            r_sub      <= bus.sub;
            // Subtraction is A + ~B + 1, so the borrow-in inverts into a carry-in.
            r_carry    <= bus.cin ^ bus.sub;
            r_idx      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 8] <= w_limb_sum;
          r_carry            <= w_c8;
          if (r_idx == LAST_IDX) begin
            r_idx       <= '0;
            r_cout      <= w_c8;
            r_ovf       <= w_c7 ^ w_c8;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl at WORDS=4 with hand-computed results.
module tb_adder_seq_ctrl;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_miss;

  adder_seq_ctrl_if #(.WORDS(WORDS)) bus ();

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int budget;
    budget = 20;
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("in_ready_timeout", {31'd0, bus.in_ready}, 1);
  endtask

  // Issue one request, check latency, optionally backpressure, then release.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int hold);
    logic [W-1:0] held_sum;
    logic         held_cout;
    wait_in_ready();
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    check({tag, "_busy_run"}, {31'd0, bus.busy}, 1);
    check({tag, "_in_ready_run"}, {31'd0, bus.in_ready}, 0);
    for (int i = 1; i < WORDS; i++) begin
      check({tag, "_early_valid"}, {31'd0, bus.out_valid}, 0);
      tick();
    end
    tick();
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 1);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    held_sum  = bus.sum;
    held_cout = bus.cout;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.op_a     = W'($urandom_range(0, 32'hFFFF));
      tick();
      check({tag, "_bp_valid"}, {31'd0, bus.out_valid}, 1);
      check({tag, "_bp_sum"}, bus.sum, held_sum);
      check({tag, "_bp_cout"}, {31'd0, bus.cout}, {31'd0, held_cout});
      check({tag, "_bp_in_ready"}, {31'd0, bus.in_ready}, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 0);
    check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 1);
    check({tag, "_busy_idle"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_sum", bus.sum, 0);
    check("rst_cout", {31'd0, bus.cout}, 0);
    check("rst_ovf", {31'd0, bus.overflow}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_state", {30'd0, dbg_state}, 0);

    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op("ovf_cin", 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
    run_op("sub_bin", 32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 0);
    run_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 0);

    // backpressure, then an immediate follow-up request
    run_op("bp", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 3);
    run_op("after_bp", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0);

    // reset during the second RUN cycle
    wait_in_ready();
    bus.op_a     = 32'h0101_0101;
    bus.op_b     = 32'h0202_0202;
    bus.sub      = 1'b0;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_state", {30'd0, dbg_state}, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    run_op("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
